// File: rtl/task_b_pkg.sv
// Shared types and widths for the Task B timer sequencer.
package task_b_pkg;

  localparam int unsigned STAGE_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/task_b_sequencer_edge_rise.sv
// Registered rising-edge detector; a level already high out of reset counts as an edge.
module edge_rise (
  input  logic clock,
  input  logic reset_n,
  input  logic in,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= in;
      pulse <= in & ~prev;
    end
  end

endmodule

// File: rtl/task_b_sequencer.sv
// Steps the Task B timer through NUM_STAGES timed stages per start edge,
// with a one-cycle run-low gap between stages so the timer re-arms.
module task_b_sequencer
  import task_b_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  btn_start,
  input  logic                  btn_abort,
  input  logic                  timer_done,
  output logic                  timer_run,
  output logic [STAGE_W-1:0]    stage,
  output logic [NUM_STAGES-1:0] led,
  output logic                  busy,
  output logic                  done_pulse
);

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  state_t                  state_q;
  state_t                  state_d;
  logic [STAGE_W-1:0]      stage_d;
  logic                    run_d;
  logic                    busy_d;
  logic                    pulse_d;
  logic [NUM_STAGES-1:0]   led_d;
  logic                    start_pulse;
  logic                    abort_q;
  logic                    start_req;

  edge_rise u_start_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .in      (btn_start),
    .pulse   (start_pulse)
  );

  // The start edge lags the button by one register, so an abort pressed
  // together with start must also mask the delayed edge.
  assign start_req = start_pulse & ~abort_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      stage      <= '0;
      timer_run  <= 1'b0;
      busy       <= 1'b0;
      led        <= '0;
      done_pulse <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage      <= stage_d;
      timer_run  <= run_d;
      busy       <= busy_d;
      led        <= led_d;
      done_pulse <= pulse_d;
      abort_q    <= btn_abort;
    end
  end

  // Next state, next stage and the registered output decode.
  always_comb begin
    state_d = state_q;
    stage_d = stage;
    unique case (state_q)
      IDLE: begin
        stage_d = '0;
        if (start_req) state_d = RUN;
      end
      RUN: begin
        if (timer_done) begin
          if (stage < LAST_STAGE) begin
            state_d = GAP;
            stage_d = stage + STAGE_W'(1);
          end else begin
            state_d = FINISH;
          end
        end
      end
      GAP:    state_d = RUN;
      FINISH: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: begin
        state_d = IDLE;
        stage_d = '0;
      end
    endcase
    if (btn_abort) begin
      state_d = IDLE;
      stage_d = '0;
    end
    run_d   = (state_d == RUN);
    busy_d  = (state_d == RUN) || (state_d == GAP);
    pulse_d = (state_d == FINISH);
    led_d   = busy_d ? (NUM_STAGES'(1) << stage_d) : '0;
  end

endmodule

// File: doc/task_b_sequencer.md
# task_b_sequencer

Controller that drives the run/enable input of the Task B interval timers and consumes their expiry flag. It steps through a configurable number of timed stages on a start-button edge, re-arms the timer between stages and reports the active stage on the LEDs. It sits between the debounced pushbuttons and the Task B timer instance, on the 100 MHz board clock.

## Interface

**Parameters**
- `NUM_STAGES`, default 4: number of timed stages per run (2..8).

**Ports**
- `clock`  in  1  100 MHz system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `btn_start`  in  1  debounced start button, level; a rising edge requests a run.
- `btn_abort`  in  1  debounced abort button, level; high forces return to idle.
- `timer_done`  in  1  expiry flag from the timer; high while expired, cleared by the timer one cycle after `timer_run` falls.
- `timer_run`  out  1  enable to the timer; timer counts while high and clears while low.
- `stage`  out  3  index of the current stage, 0..NUM_STAGES-1.
- `led`  out  NUM_STAGES  one-hot copy of `stage` while busy; all zero otherwise.
- `busy`  out  1  high from the first RUN cycle to the last RUN cycle.
- `done_pulse`  out  1  single-cycle pulse when the final stage expires.

## Operation

- **States:** IDLE, RUN, GAP, FINISH.
- **IDLE**
  - `timer_run`=0, `busy`=0, `stage`=0.
  - A rising edge on `btn_start` (registered previous value) moves to RUN.
- **RUN**
  - `timer_run`=1, `busy`=1.
  - On `timer_done`=1:
    - if `stage` < NUM_STAGES-1: go to GAP and increment `stage`;
    - else: go to FINISH.
- **GAP**
  - Exactly one cycle, `timer_run`=0.
  - `timer_done` is ignored, because it is stale from the previous stage.
  - Always goes to RUN.
- **FINISH**
  - `timer_run`=0, `busy`=0, `done_pulse`=1 for this cycle only.
  - Goes to IDLE; `stage` returns to 0.
- **Abort:** `btn_abort`=1 in any state goes to IDLE next cycle and clears all outputs. Abort has priority over start, `timer_done` and the stage increment.
- **Start while not IDLE:** a start edge in RUN, GAP or FINISH is ignored and is not queued.
- **`timer_done` in IDLE or FINISH:** ignored.
- **Held `btn_start`:** holding the button after a run completes does not restart; a new rising edge is required.
- **Reset value of every output:** 0, including `stage` and `led`. Reset mid-run returns to IDLE immediately and asynchronously. The edge-detect register resets to 0, so a button already held high at reset release counts as an edge.

## Timing

- All outputs are registered. `timer_run`, `busy`, `led` and `done_pulse` are decoded from the state register, with no combinational path from inputs.
- **Start:** `btn_start` rises before edge t → `timer_run`=1 and `busy`=1 from edge t+1.
- **Stage change:** `timer_done` is sampled high at edge d.
  - Edge d+1: `timer_run`=0 and `stage` incremented (GAP).
  - Edge d+2: `timer_run`=1 (RUN).
  - The timer sees run low for exactly one cycle.
- **Final expiry:** `done_pulse` and `busy`=0 at edge d+1; IDLE at edge d+2.
- **Stage duration:** the timer period plus 2 cycles of sequencer overhead per stage.

## Structure

- Shared package `task_b_pkg`:
  - state enum (IDLE, RUN, GAP, FINISH, 2-bit encoding);
  - `STAGE_W` = 3.
- Sub-module `edge_rise`:
  - registered rising-edge detector (clock, reset_n, in → pulse);
  - used for `btn_start`.
- The FSM and stage counter stay in the top file.

## Test plan

The bench uses a timer model that asserts `timer_done` 5 cycles after `timer_run` rises, holds it while `timer_run`=1, and clears it 1 cycle after `timer_run` falls. NUM_STAGES=4 unless stated.

- **Full run:** `btn_start` 0→1 → `stage` steps 0,1,2,3; `led` 0001,0010,0100,1000; exactly three 1-cycle `timer_run` gaps; one `done_pulse`; back to IDLE with `led`=0000.
- **Abort:** assert `btn_abort` in stage 2, RUN → IDLE next edge; `timer_run`=0, `stage`=0, no `done_pulse`. Start and abort on the same cycle → stays IDLE.
- **Repeat start:** second `btn_start` edge during stage 1 → ignored, stage sequence unchanged. `btn_start` held high through FINISH → no restart.
- **Stale done:** `timer_done` forced high during GAP → stage increments exactly once, not twice.
- **Reset:** `reset_n` low mid-stage 1, asynchronous → all outputs 0 before the next clock edge; after release, new start edge → run begins at stage 0.
- **Parameter edge:** NUM_STAGES=2 → stages 0,1; `done_pulse` on the 2nd expiry + 1 cycle.
